// File: rtl/iccm_boot_pkg.sv
// Shared types and defaults for the UART-to-ICCM boot loader.
package iccm_boot_pkg;

  typedef enum logic [2:0] {
    IdleSt  = 3'd0,
    LoadSt  = 3'd1,
    CheckSt = 3'd2,
    DoneSt  = 3'd3,
    ErrSt   = 3'd4
  } boot_state_e;

  localparam logic [31:0] TermWordDefault = 32'h0000_0FFF;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for slow asynchronous level inputs.
module prim_flop_2sync #(
  parameter int unsigned Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      q_o    <= ResetValue;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/iccm_boot_loader.sv
// Assembles UART bytes into little-endian words, writes them to sequential ICCM
// addresses and releases the core only after terminator + XOR checksum match.
module iccm_boot_loader
  import iccm_boot_pkg::*;
#(
  parameter int unsigned AddrW         = 12,
  parameter logic [31:0] TermWord      = TermWordDefault,
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             prog_i,
  input  logic             rx_dv_i,
  input  logic [7:0]       rx_byte_i,
  output logic             we_o,
  output logic [AddrW-1:0] addr_o,
  output logic [31:0]      wdata_o,
  output logic             reset_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       state_o
);

  // Handshake: rx_dv_i is a one-cycle strobe with no ready (every byte must be
  // taken), and we_o is a one-cycle strobe the ICCM always accepts.

  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TimeoutCycles);

  localparam logic [2:0] StIdle  = IdleSt;
  localparam logic [2:0] StLoad  = LoadSt;
  localparam logic [2:0] StCheck = CheckSt;
  localparam logic [2:0] StDone  = DoneSt;
  localparam logic [2:0] StErr   = ErrSt;

  logic            prog_sync, prog_q, prog_rise;
  logic [2:0]      state_q, state_d;
  logic [1:0]      bcnt_q;
  logic [23:0]     part_q;
  logic [AddrW:0]  wcnt_q;
  logic [31:0]     acc_q, wdata_q;
  logic            we_q, reset_q;
  logic [TmoW-1:0] tmo_q;
  logic            active, start, word_dv, tmo_hit, do_write;
  logic [31:0]     word;

  prim_flop_2sync #(.Width(1)) u_prog_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (prog_i),
    .q_o    (prog_sync)
  );

  assign prog_rise = prog_sync & ~prog_q;
  assign active    = (state_q == StLoad) || (state_q == StCheck);
  assign start     = prog_rise && !active;
  assign word      = {rx_byte_i, part_q};
  assign word_dv   = active && rx_dv_i && (bcnt_q == 2'd3);
  // Only a partially received word can time out; gaps between words are free.
  assign tmo_hit   = active && (bcnt_q != 2'd0) && (tmo_q == TmoMax);

  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    if (start) begin
      state_d = StLoad;
    end else if (tmo_hit) begin
      state_d = StErr;
    end else if (word_dv) begin
      if (state_q == StLoad) begin
        if (word == TermWord) begin
          state_d = StCheck;
        end else if (wcnt_q[AddrW]) begin
          state_d = StErr;
        end else begin
          do_write = 1'b1;
        end
      end else begin
        state_d = (word == acc_q) ? StDone : StErr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_q  <= 1'b0;
      state_q <= StIdle;
      bcnt_q  <= '0;
      part_q  <= '0;
      wcnt_q  <= '0;
      acc_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      reset_q <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      prog_q  <= prog_sync;
      state_q <= state_d;
      we_q    <= do_write;
      reset_q <= (state_d == StIdle) || (state_d == StDone);
      done_o  <= (state_d == StDone);
      err_o   <= (state_d == StErr);
      if (do_write) begin
        wdata_q <= word;
      end
      if (start) begin
        bcnt_q <= '0;
        wcnt_q <= '0;
        acc_q  <= '0;
        tmo_q  <= '0;
      end else begin
        // The address advances one cycle after the write so addr_o stays
        // stable for the whole we_o cycle.
        if (we_q) begin
          wcnt_q <= wcnt_q + 1'b1;
        end
        if (active && rx_dv_i) begin
          bcnt_q <= bcnt_q + 1'b1;
          case (bcnt_q)
            2'd0:    part_q[7:0]   <= rx_byte_i;
            2'd1:    part_q[15:8]  <= rx_byte_i;
            2'd2:    part_q[23:16] <= rx_byte_i;
            default: part_q        <= part_q;
          endcase
        end
        if (do_write) begin
          acc_q <= acc_q ^ word;
        end
        if (!active || (bcnt_q == 2'd0) || rx_dv_i) begin
          tmo_q <= '0;
        end else if (tmo_q != TmoMax) begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign we_o    = we_q;
  assign addr_o  = wcnt_q[AddrW-1:0];
  assign wdata_o = wdata_q;
  assign reset_o = reset_q;
  assign state_o = state_q;

endmodule
